stallable_control_fsm: RTL and testbench
========================================

// Module: stallable_control_fsm
// PURPOSE
//  Multi-cycle control FSM for the RV32I core. Decodes opcode/funct3 into datapath control lines.
//  Sequences 1-cycle and 2-cycle (load, sb/sh) instructions. Adds a ready-handshake memory interface
//  with bounded wait states, an encoded halt cause, resume-after-ecall, and a retired-instruction counter.
//  Sits between the instruction register and RegisterFile/MemoryController/ProgramCounter/BranchALU.
// PARAMETERS
//  MEM_WAIT_MAX   16  max consecutive cycles with mem_ready=0 before a timeout halt (>=1)
//  RETIRE_W       32  width of retired-instruction counter
//  STALL_W        16  width of stall counter (CTRL_STALL_COUNT_EN only)
// PORTS
//  clock          in   1         state updates on posedge
//  reset          in   1         reset, asynchronous, active-high
//  opcode         in   7         current instruction opcode
//  funct3         in   3         current instruction funct3
//  mem_ready      in   1         memory completed the request presented this cycle
//  pc_misaligned  in   1         error flag from ProgramCounter
//  mem_unaligned  in   1         error flag from MemoryController
//  mem_bad_funct3 in   1         error flag from MemoryController
//  resume         in   1         debug resume request, honoured only in HALT with cause ECALL
//  rd_write_en    out  1         RegisterFile write enable
//  mem_mode       out  2         0=NOP 1=LOAD 2=STORE_PRELOAD 3=STORE
//  mem_req        out  1         high whenever mem_mode!=NOP
//  rd_src         out  4         one-hot {branch,imm,alu,mem}; 0 when rd_write_en=0
//  pc_write_en    out  1         ProgramCounter write enable
//  iaddr_next     out  1         1=fetch NEXT_PC, 0=fetch CURRENT_PC
//  op_imm         out  1         ALU OP-IMM select
//  imm_auipc      out  1         ImmediateFormer: 0=LUI 1=AUIPC
//  branch_mode    out  2         0=INCREMENT 1=JAL 2=JALR 3=BRANCH
//  halted         out  1         state==HALT
//  halt_cause     out  3         0 none,1 ECALL,2 PC_MISALIGN,3 MEM_UNALIGN,4 BAD_FUNCT3,5 BAD_OPCODE,6 TIMEOUT
//  retired        out  RETIRE_W  instructions completed
//  stall_cycles   out  STALL_W   mem wait cycles (0 without macro)
// BEHAVIOUR
//  - States: INIT, RUN, MEM1, HALT. Reset (async): state=INIT, halt_cause=0, retired=0, stall_cycles=0, wait_cnt=0.
//  - All outputs not actively used are driven 0, never X. INIT/HALT: every enable 0, mem_mode=NOP.
//    INIT additionally drives iaddr_next=0.
//  - INIT -> RUN unconditionally after one cycle (initial fetch).
//  - RUN, 1-cycle ops (lui/auipc/jal/jalr/branch/OP-IMM/OP/fence/sw): assert pc_write_en=1, iaddr_next=1,
//    set op-specific lines as in the RV32I decode table; retired+=1 that cycle.
//  - Two-cycle ops: load, or store with funct3!=010. RUN -> MEM1 without asserting pc_write_en.
//  - MEM1: mem_mode=LOAD (load) or STORE_PRELOAD (sb/sh), iaddr_next=0. Hold until mem_ready=1, then go to RUN.
//    In the following RUN cycle the second phase issues (load: LOAD + rd_write_en, rd_src=mem; store: STORE).
//  - Any RUN cycle with mem_req=1 (load/store final phase, sw) commits only when mem_ready=1.
//    While mem_ready=0: pc_write_en=0, rd_write_en=0, mem_mode held, retired unchanged.
//  - wait_cnt counts consecutive mem_req&~mem_ready cycles and clears on mem_ready.
//    When wait_cnt reaches MEM_WAIT_MAX -> HALT, cause TIMEOUT.
//  - ecall/ebreak (1110011): pc_write_en=0, next state HALT, cause ECALL. Unknown opcode -> HALT, cause BAD_OPCODE.
//  - Error inputs force HALT from RUN/MEM1 at the next edge (INIT ignores them).
//    Priority when simultaneous: PC_MISALIGN > MEM_UNALIGN > BAD_FUNCT3 > TIMEOUT > BAD_OPCODE > ECALL.
//    Whenever an error halt is taken this cycle, all enables are 0, so no register or PC commit occurs.
//  - halt_cause is latched on entry to HALT and held until reset or resume.
//  - HALT: with resume=1 and cause=ECALL, one cycle of pc_write_en=1, iaddr_next=1, branch_mode=INCREMENT,
//    then next state RUN, cause cleared to 0, retired+=1. Resume is ignored for all other causes.
//  - retired wraps modulo 2^RETIRE_W.
//  - Reset mid-operation (any state, including MEM1 wait) returns to INIT immediately. No commit occurs.
// CONFIGURATION
//  CTRL_STALL_COUNT_EN defined: stall_cycles += 1 each cycle with mem_req&~mem_ready, saturating at 2^STALL_W-1.
//  Undefined: no counter logic, stall_cycles tied to 0.
// TESTING
//  1. Reset, then addi (0010011) with mem_ready=1 -> INIT 1 cycle, then RUN; op_imm=1, rd_src=0010, pc_write_en=1, retired=1.
//  2. lw with mem_ready low for 3 cycles in MEM1 -> MEM1 held 3 cycles; then RUN LOAD, rd_write_en=1, rd_src=0001;
//     retired+1; stall_cycles=3 with macro, 0 without.
//  3. sw with mem_ready=0 for MEM_WAIT_MAX=4 cycles -> HALT, halt_cause=6, pc_write_en never asserted.
//  4. ecall -> HALT, cause=1; resume=1 -> one cycle pc_write_en=1, branch_mode=0; then RUN, cause=0.
//  5. pc_misaligned and mem_bad_funct3 asserted together in RUN -> HALT, cause=2; resume ignored.
//  6. Opcode 0000000 -> HALT cause=5. Async reset asserted mid-MEM1 -> INIT next, outputs 0, retired=0.

Source files
------------

// File: rtl/stallable_control_fsm.sv
// Multi-cycle RV32I control FSM with ready-handshake memory stalls, encoded halt cause,
// ecall resume and a retired-instruction counter. Optional stall counter: CTRL_STALL_COUNT_EN.
module stallable_control_fsm #(
  parameter int MEM_WAIT_MAX = 16,
  parameter int RETIRE_W     = 32,
  parameter int STALL_W      = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic                mem_ready,
  input  logic                pc_misaligned,
  input  logic                mem_unaligned,
  input  logic                mem_bad_funct3,
  input  logic                resume,
  output logic                rd_write_en,
  output logic [1:0]          mem_mode,
  output logic                mem_req,
  output logic [3:0]          rd_src,
  output logic                pc_write_en,
  output logic                iaddr_next,
  output logic                op_imm,
  output logic                imm_auipc,
  output logic [1:0]          branch_mode,
  output logic                halted,
  output logic [2:0]          halt_cause,
  output logic [RETIRE_W-1:0] retired,
  output logic [STALL_W-1:0]  stall_cycles
);
  localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] MM_NOP     = 2'd0;
  localparam logic [1:0] MM_LOAD    = 2'd1;
  localparam logic [1:0] MM_PRELOAD = 2'd2;
  localparam logic [1:0] MM_STORE   = 2'd3;

  localparam logic [2:0] CAUSE_NONE        = 3'd0;
  localparam logic [2:0] CAUSE_ECALL       = 3'd1;
  localparam logic [2:0] CAUSE_PC_MISALIGN = 3'd2;
  localparam logic [2:0] CAUSE_MEM_UNALIGN = 3'd3;
  localparam logic [2:0] CAUSE_BAD_FUNCT3  = 3'd4;
  localparam logic [2:0] CAUSE_BAD_OPCODE  = 3'd5;
  localparam logic [2:0] CAUSE_TIMEOUT     = 3'd6;

  typedef enum logic [1:0] {INIT, RUN, MEM1, HALT} state_t;

  state_t            state;
  logic              second_phase;
  logic [WAIT_W-1:0] wait_cnt;
  logic              is_load, two_cycle, known_op, active, input_err, first_run;
  logic              stall, timeout;
  logic [2:0]        cause_sel;

  assign is_load   = (opcode == OPC_LOAD);
  assign two_cycle = is_load || (opcode == OPC_STORE && funct3 != 3'b010);
  assign active    = (state == RUN) || (state == MEM1);
  assign input_err = active && (pc_misaligned || mem_unaligned || mem_bad_funct3);
  assign first_run = (state == RUN) && !second_phase;
  assign halted    = (state == HALT);

  always_comb begin
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE,
      OPC_OPIMM, OPC_OP, OPC_FENCE, OPC_SYSTEM: known_op = 1'b1;
      default:                                  known_op = 1'b0;
    endcase
  end

  // Decode for the current cycle; stalls and error halts then strip the commit enables.
  always_comb begin
    rd_write_en = 1'b0;
    mem_mode    = MM_NOP;
    rd_src      = 4'b0000;
    pc_write_en = 1'b0;
    iaddr_next  = 1'b0;
    op_imm      = 1'b0;
    imm_auipc   = 1'b0;
    branch_mode = 2'd0;
    case (state)
      RUN: begin
        if (second_phase) begin
          pc_write_en = 1'b1;
          iaddr_next  = 1'b1;
          if (is_load) begin
            mem_mode    = MM_LOAD;
            rd_write_en = 1'b1;
            rd_src      = 4'b0001;
          end else begin
            mem_mode = MM_STORE;
          end
        end else if (!two_cycle) begin
          case (opcode)
            OPC_LUI:    begin pc_write_en = 1'b1; iaddr_next = 1'b1; rd_write_en = 1'b1; rd_src = 4'b0100; end
            OPC_AUIPC:  begin pc_write_en = 1'b1; iaddr_next = 1'b1; rd_write_en = 1'b1; rd_src = 4'b0100; imm_auipc = 1'b1; end
            OPC_JAL:    begin pc_write_en = 1'b1; iaddr_next = 1'b1; rd_write_en = 1'b1; rd_src = 4'b1000; branch_mode = 2'd1; end
            OPC_JALR:   begin pc_write_en = 1'b1; iaddr_next = 1'b1; rd_write_en = 1'b1; rd_src = 4'b1000; branch_mode = 2'd2; end
            OPC_BRANCH: begin pc_write_en = 1'b1; iaddr_next = 1'b1; branch_mode = 2'd3; end
            OPC_OPIMM:  begin pc_write_en = 1'b1; iaddr_next = 1'b1; rd_write_en = 1'b1; rd_src = 4'b0010; op_imm = 1'b1; end
            OPC_OP:     begin pc_write_en = 1'b1; iaddr_next = 1'b1; rd_write_en = 1'b1; rd_src = 4'b0010; end
            OPC_FENCE:  begin pc_write_en = 1'b1; iaddr_next = 1'b1; end
            OPC_STORE:  begin pc_write_en = 1'b1; iaddr_next = 1'b1; mem_mode = MM_STORE; end
            default:    ;
          endcase
        end
      end
      MEM1:    mem_mode = is_load ? MM_LOAD : MM_PRELOAD;
      HALT: begin
        if (resume && halt_cause == CAUSE_ECALL) begin
          pc_write_en = 1'b1;
          iaddr_next  = 1'b1;
        end
      end
      default: ;
    endcase
    if (mem_mode != MM_NOP && !mem_ready) begin
      pc_write_en = 1'b0;
      rd_write_en = 1'b0;
      rd_src      = 4'b0000;
    end
    if (input_err) begin
      rd_write_en = 1'b0;
      mem_mode    = MM_NOP;
      rd_src      = 4'b0000;
      pc_write_en = 1'b0;
      iaddr_next  = 1'b0;
      op_imm      = 1'b0;
      imm_auipc   = 1'b0;
      branch_mode = 2'd0;
    end
    mem_req = (mem_mode != MM_NOP);
  end

  assign stall   = mem_req && !mem_ready;
  assign timeout = stall && (wait_cnt == WAIT_W'(MEM_WAIT_MAX - 1));

  always_comb begin
    cause_sel = CAUSE_NONE;
    if (active) begin
      if (pc_misaligned)                        cause_sel = CAUSE_PC_MISALIGN;
      else if (mem_unaligned)                   cause_sel = CAUSE_MEM_UNALIGN;
      else if (mem_bad_funct3)                  cause_sel = CAUSE_BAD_FUNCT3;
      else if (timeout)                         cause_sel = CAUSE_TIMEOUT;
      else if (first_run && !known_op)          cause_sel = CAUSE_BAD_OPCODE;
      else if (first_run && opcode == OPC_SYSTEM) cause_sel = CAUSE_ECALL;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= INIT;
      second_phase <= 1'b0;
      wait_cnt     <= '0;
      halt_cause   <= CAUSE_NONE;
      retired      <= '0;
    end else begin
      retired  <= retired + RETIRE_W'(pc_write_en);
      wait_cnt <= stall ? wait_cnt + 1'b1 : '0;
      case (state)
        INIT: begin
          state        <= RUN;
          second_phase <= 1'b0;
        end
        RUN, MEM1: begin
          if (cause_sel != CAUSE_NONE) begin
            state        <= HALT;
            halt_cause   <= cause_sel;
            second_phase <= 1'b0;
            wait_cnt     <= '0;
          end else if (state == MEM1) begin
            if (mem_ready) begin
              state        <= RUN;
              second_phase <= 1'b1;
            end
          end else if (second_phase) begin
            if (mem_ready) second_phase <= 1'b0;
          end else if (two_cycle) begin
            state <= MEM1;
          end
        end
        HALT: begin
          if (resume && halt_cause == CAUSE_ECALL) begin
            state      <= RUN;
            halt_cause <= CAUSE_NONE;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

`ifdef CTRL_STALL_COUNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                  stall_cycles <= '0;
    else if (stall && stall_cycles != '1)       stall_cycles <= stall_cycles + 1'b1;
  end
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_stallable_control_fsm.sv
// Self-checking bench for stallable_control_fsm: directed scenarios followed by random
// instruction streams compared against an instruction-level reference model.
module tb_stallable_control_fsm;
  localparam int MAXW = 4;
  localparam int RW   = 8;
  localparam int SW   = 4;
`ifdef CTRL_STALL_COUNT_EN
  localparam bit STALL_ON = 1'b1;
`else
  localparam bit STALL_ON = 1'b0;
`endif

  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111;
  localparam logic [6:0] BR = 7'b1100011, LD = 7'b0000011, ST = 7'b0100011, OPIMM = 7'b0010011;
  localparam logic [6:0] OP = 7'b0110011, FENCE = 7'b0001111, SYS = 7'b1110011;

  logic clock = 1'b0, reset = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic mem_ready = 1'b0, pc_misaligned = 1'b0, mem_unaligned = 1'b0, mem_bad_funct3 = 1'b0, resume = 1'b0;
  logic rd_write_en, mem_req, pc_write_en, iaddr_next, op_imm, imm_auipc, halted;
  logic [1:0] mem_mode, branch_mode;
  logic [3:0] rd_src;
  logic [2:0] halt_cause;
  logic [RW-1:0] retired;
  logic [SW-1:0] stall_cycles;

  stallable_control_fsm #(.MEM_WAIT_MAX(MAXW), .RETIRE_W(RW), .STALL_W(SW)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct3(funct3), .mem_ready(mem_ready),
    .pc_misaligned(pc_misaligned), .mem_unaligned(mem_unaligned), .mem_bad_funct3(mem_bad_funct3),
    .resume(resume), .rd_write_en(rd_write_en), .mem_mode(mem_mode), .mem_req(mem_req),
    .rd_src(rd_src), .pc_write_en(pc_write_en), .iaddr_next(iaddr_next), .op_imm(op_imm),
    .imm_auipc(imm_auipc), .branch_mode(branch_mode), .halted(halted), .halt_cause(halt_cause),
    .retired(retired), .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  int tests = 0, fails = 0;
  // Model: m_step counts progress through the current instruction (0 issue, 1 memory prep, 2 final access).
  bit m_init, m_halted, m_fetch;
  int m_cause, m_step, m_wait, m_stall, m_retired;
  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  int halt_age = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ctrlBundle();
    return {14'd0, rd_write_en, mem_mode, mem_req, rd_src, pc_write_en, iaddr_next,
            op_imm, imm_auipc, branch_mode, halted, halt_cause};
  endfunction

  task automatic applyReset();
    #2 reset = 1'b1;
    opcode = '0; funct3 = '0; mem_ready = 1'b0; resume = 1'b0;
    pc_misaligned = 1'b0; mem_unaligned = 1'b0; mem_bad_funct3 = 1'b0;
    #1;
    checkOutput("reset_ctrl", ctrlBundle(), 32'd0);
    checkOutput("reset_retired", 32'(retired), 32'd0);
    checkOutput("reset_stall", 32'(stall_cycles), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    m_init = 1; m_halted = 0; m_fetch = 1; m_cause = 0; m_step = 0; m_wait = 0; m_stall = 0; m_retired = 0;
  endtask

  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input bit rdy,
                               input bit pcm, input bit una, input bit bf3, input bit res);
    logic e_rdwe, e_pcwe, e_iaddr, e_opimm, e_auipc;
    logic [1:0] e_mm, e_bm;
    logic [3:0] e_src;
    bit ld, st, memop, stalled, n_init, n_halted, n_fetch;
    int halt_to, n_cause, n_step, n_wait, n_stall, n_ret;
    opcode = op; funct3 = f3; mem_ready = rdy; pc_misaligned = pcm; mem_unaligned = una;
    mem_bad_funct3 = bf3; resume = res;
    #1;
    e_rdwe = 0; e_pcwe = 0; e_iaddr = 0; e_opimm = 0; e_auipc = 0; e_mm = 0; e_bm = 0; e_src = 0;
    memop = 0; stalled = 0; halt_to = 0;
    n_init = m_init; n_halted = m_halted; n_fetch = m_fetch; n_cause = m_cause;
    n_step = m_step; n_wait = 0; n_stall = m_stall;
    ld = (op == LD); st = (op == ST);
    if (m_init) begin
      n_init = 0; n_fetch = 1;
    end else if (m_halted) begin
      if (res && m_cause == 1) begin
        e_pcwe = 1; e_iaddr = 1; n_halted = 0; n_cause = 0; n_step = 0; n_fetch = 1;
      end
    end else begin
      case (m_step)
        0: begin
          if (ld || (st && f3 != 3'd2)) n_step = 1;
          else if (st) begin memop = 1; e_mm = 3; e_pcwe = 1; e_iaddr = 1; end
          else if (op == SYS) halt_to = 1;
          else begin
            e_pcwe = 1; e_iaddr = 1;
            case (op)
              LUI:     begin e_rdwe = 1; e_src = 4'b0100; end
              AUIPC:   begin e_rdwe = 1; e_src = 4'b0100; e_auipc = 1; end
              JAL:     begin e_rdwe = 1; e_src = 4'b1000; e_bm = 1; end
              JALR:    begin e_rdwe = 1; e_src = 4'b1000; e_bm = 2; end
              BR:      e_bm = 3;
              OPIMM:   begin e_rdwe = 1; e_src = 4'b0010; e_opimm = 1; end
              OP:      begin e_rdwe = 1; e_src = 4'b0010; end
              FENCE:   ;
              default: begin e_pcwe = 0; e_iaddr = 0; halt_to = 5; end
            endcase
          end
        end
        1: begin memop = 1; e_mm = ld ? 2'd1 : 2'd2; if (rdy) n_step = 2; end
        default: begin
          memop = 1; e_pcwe = 1; e_iaddr = 1;
          if (ld) begin e_mm = 1; e_rdwe = 1; e_src = 4'b0001; end
          else e_mm = 3;
        end
      endcase
      if (memop && !rdy) begin stalled = 1; e_pcwe = 0; e_rdwe = 0; e_src = 0; end
      if (pcm || una || bf3) begin
        e_rdwe = 0; e_pcwe = 0; e_iaddr = 0; e_opimm = 0; e_auipc = 0; e_mm = 0; e_bm = 0; e_src = 0;
        stalled = 0;
        halt_to = pcm ? 2 : (una ? 3 : 4);
      end else if (stalled && m_wait + 1 == MAXW) begin
        halt_to = 6;
      end
      n_wait = stalled ? m_wait + 1 : 0;
      if (stalled && m_stall < 2**SW - 1) n_stall = m_stall + 1;
      if (halt_to != 0) begin
        n_halted = 1; n_cause = halt_to; n_step = 0; n_wait = 0;
      end else if (e_pcwe) begin
        n_step = 0; n_fetch = 1;
      end
    end
    n_ret = (m_retired + int'(e_pcwe)) % (2**RW);
    checkOutput("ctrl", ctrlBundle(),
                {14'd0, e_rdwe, e_mm, (e_mm != 2'd0), e_src, e_pcwe, e_iaddr, e_opimm, e_auipc,
                 e_bm, m_halted, 3'(m_cause)});
    checkOutput("retired", 32'(retired), 32'(m_retired));
    checkOutput("stall_cycles", 32'(stall_cycles), STALL_ON ? 32'(m_stall) : 32'd0);
    @(posedge clock);
    m_init = n_init; m_halted = n_halted; m_fetch = n_fetch; m_cause = n_cause;
    m_step = n_step; m_wait = n_wait; m_stall = n_stall; m_retired = n_ret;
    @(negedge clock);
  endtask

  function automatic logic [6:0] pickOp();
    logic [6:0] ops [12] = '{LUI, AUIPC, JAL, JALR, BR, LD, ST, ST, OPIMM, OP, FENCE, SYS};
    int k = $urandom_range(0, 12);
    return (k == 12) ? 7'b1111111 : ops[k];
  endfunction

  initial begin
    @(negedge clock);
    applyReset();
    applyStimulus(OPIMM, 3'd0, 1, 0, 0, 0, 0);
    applyStimulus(OPIMM, 3'd0, 1, 0, 0, 0, 0);
    checkOutput("t1_retired", 32'(retired), 32'd1);

    applyStimulus(LD, 3'd2, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(LD, 3'd2, 0, 0, 0, 0, 0);
    applyStimulus(LD, 3'd2, 1, 0, 0, 0, 0);
    applyStimulus(LD, 3'd2, 1, 0, 0, 0, 0);
    checkOutput("t2_retired", 32'(retired), 32'd2);
    checkOutput("t2_stall", 32'(stall_cycles), STALL_ON ? 32'd3 : 32'd0);

    for (int i = 0; i < MAXW; i++) applyStimulus(ST, 3'd2, 0, 0, 0, 0, 0);
    checkOutput("t3_halted", 32'(halted), 32'd1);
    checkOutput("t3_cause", 32'(halt_cause), 32'd6);
    applyStimulus(ST, 3'd2, 1, 0, 0, 0, 1);
    checkOutput("t3_resume_ignored", 32'(halted), 32'd1);

    applyReset();
    applyStimulus(SYS, 3'd0, 1, 0, 0, 0, 0);
    applyStimulus(SYS, 3'd0, 1, 0, 0, 0, 0);
    checkOutput("t4_cause", 32'(halt_cause), 32'd1);
    applyStimulus(SYS, 3'd0, 1, 0, 0, 0, 1);
    checkOutput("t4_halted", 32'(halted), 32'd0);
    checkOutput("t4_cause_clr", 32'(halt_cause), 32'd0);
    checkOutput("t4_retired", 32'(retired), 32'd1);
    applyStimulus(OPIMM, 3'd0, 1, 0, 0, 0, 0);

    applyStimulus(OPIMM, 3'd0, 1, 1, 0, 1, 0);
    checkOutput("t5_cause", 32'(halt_cause), 32'd2);
    applyStimulus(OPIMM, 3'd0, 1, 0, 0, 0, 1);
    checkOutput("t5_resume_ignored", 32'(halted), 32'd1);

    applyReset();
    applyStimulus(7'd0, 3'd0, 1, 0, 0, 0, 0);
    applyStimulus(7'd0, 3'd0, 1, 0, 0, 0, 0);
    checkOutput("t6_cause", 32'(halt_cause), 32'd5);
    applyReset();
    applyStimulus(LD, 3'd0, 1, 0, 0, 0, 0);
    applyStimulus(LD, 3'd0, 1, 0, 0, 0, 0);
    applyStimulus(LD, 3'd0, 0, 0, 0, 0, 0);
    applyReset();

    applyStimulus(OPIMM, 3'd0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 260; i++) applyStimulus(OPIMM, 3'd0, 1, 0, 0, 0, 0);
    checkOutput("retired_wrap", 32'(retired), 32'd4);

    applyReset();
    applyStimulus(LD, 3'd0, 1, 0, 0, 0, 0);
    for (int n = 0; n < 6; n++) begin
      applyStimulus(LD, 3'd0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) applyStimulus(LD, 3'd0, 0, 0, 0, 0, 0);
      applyStimulus(LD, 3'd0, 1, 0, 0, 0, 0);
      applyStimulus(LD, 3'd0, 1, 0, 0, 0, 0);
    end
    checkOutput("stall_saturate", 32'(stall_cycles), STALL_ON ? 32'd15 : 32'd0);

    applyReset();
    for (int i = 0; i < 3000; i++) begin
      if (m_fetch) begin
        cur_op = pickOp();
        cur_f3 = 3'($urandom_range(0, 7));
        m_fetch = 0;
      end
      halt_age = m_halted ? halt_age + 1 : 0;
      if ((m_halted && m_cause != 1 && halt_age > 2) || $urandom_range(0, 299) == 0) begin
        applyReset();
        halt_age = 0;
      end else begin
        applyStimulus(cur_op, cur_f3, $urandom_range(0, 3) != 0, $urandom_range(0, 79) == 0,
                      $urandom_range(0, 79) == 0, $urandom_range(0, 79) == 0,
                      m_halted ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
